// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encoding, the x0 register index and the MUL/DIV occupancy counter width.
package pipeline_stall_controller_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0  = 5'd0;
    localparam int         CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic src_hit(
        input logic       uses,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return uses && (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_counter.sv
// Remaining-occupancy counter for a multi-cycle MUL/DIV in EX: loads LAT-1,
// decrements while busy and holds at 1 so a frozen pipeline cannot overrun it.
module muldiv_latency_counter
    import pipeline_stall_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_one
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count > CNT_ONE)) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == CNT_ONE);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates dmem wait,
// MUL/DIV occupancy, taken branches, load-use hazards and imem wait.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_write_addr,
    input  logic       ex_mem_read,
    input  logic       ex_muldiv_start,
    input  logic       ex_is_div,
    input  logic       ex_branch_taken,
    input  logic       imem_busywait,
    input  logic       dmem_busywait,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       muldiv_busy,
    output logic       muldiv_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t r_state;
    logic   r_done;

    logic   w_in_muldiv;
    logic   w_start;
    logic   w_exit;
    logic   w_load_use;
    logic   w_cnt_zero;
    logic   w_cnt_one;

    assign w_in_muldiv = (r_state == ST_MULDIV);
    // The instruction is re-presented in EX during the done cycle; it must not restart.
    assign w_start     = (r_state == ST_RUN) && ex_muldiv_start && !r_done;
    assign w_exit      = w_in_muldiv && (w_cnt_one || w_cnt_zero) && !dmem_busywait;
    assign w_load_use  = ex_mem_read && (ex_write_addr != REG_X0) &&
                         (src_hit(id_uses_rs1, id_rs1_addr, ex_write_addr) ||
                          src_hit(id_uses_rs2, id_rs2_addr, ex_write_addr));

    muldiv_latency_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start && !dmem_busywait),
        .i_load_val (ex_is_div ? DIV_LOAD : MUL_LOAD),
        .i_dec      (w_in_muldiv),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    // Done is held through a dmem freeze so the re-presented op is not restarted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_exit || (r_done && dmem_busywait);
            case (r_state)
                ST_RUN:    if (w_start && !dmem_busywait) r_state <= ST_MULDIV;
                ST_MULDIV: if (w_exit) r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset || dmem_busywait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_in_muldiv || w_start) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (imem_busywait) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    assign muldiv_busy = !reset && w_in_muldiv;
    assign muldiv_done = r_done;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with hand-computed control vectors.
module tb_pipeline_stall_controller;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_write_addr;
    logic       ex_mem_read;
    logic       ex_muldiv_start;
    logic       ex_is_div;
    logic       ex_branch_taken;
    logic       imem_busywait;
    logic       dmem_busywait;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush;
    logic       muldiv_busy, muldiv_done;

    int checks = 0;
    int errors = 0;
    int idex_low;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, busy, done}
    localparam logic [9:0] V_ZERO  = 10'b00000_000_00;
    localparam logic [9:0] V_RUN   = 10'b11111_000_00;
    localparam logic [9:0] V_DONE  = 10'b11111_000_01;
    localparam logic [9:0] V_START = 10'b00011_001_00;
    localparam logic [9:0] V_MD    = 10'b00011_001_10;
    localparam logic [9:0] V_FRZMD = 10'b00000_000_10;
    localparam logic [9:0] V_LU    = 10'b00111_010_00;
    localparam logic [9:0] V_BR    = 10'b11111_110_00;
    localparam logic [9:0] V_IM    = 10'b01111_100_00;

    pipeline_stall_controller #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_write_addr   (ex_write_addr),
        .ex_mem_read     (ex_mem_read),
        .ex_muldiv_start (ex_muldiv_start),
        .ex_is_div       (ex_is_div),
        .ex_branch_taken (ex_branch_taken),
        .imem_busywait   (imem_busywait),
        .dmem_busywait   (dmem_busywait),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic idle();
        id_rs1_addr     = 5'd0;
        id_rs2_addr     = 5'd0;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_write_addr   = 5'd0;
        ex_mem_read     = 1'b0;
        ex_muldiv_start = 1'b0;
        ex_is_div       = 1'b0;
        ex_branch_taken = 1'b0;
        imem_busywait   = 1'b0;
        dmem_busywait   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy, muldiv_done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        ex_branch_taken = 1'b1;
        @(negedge clk); #1 chk("reset_hold", V_ZERO);

        @(negedge clk); reset = 1'b0; idle(); #1 chk("post_reset", V_RUN);

        // Load-use hazards
        @(negedge clk); ex_mem_read = 1'b1; ex_write_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        #1 chk("lu_rs1", V_LU);
        @(negedge clk); idle(); #1 chk("lu_bubble", V_RUN);
        @(negedge clk); ex_mem_read = 1'b1; ex_write_addr = 5'd0; id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1;
        #1 chk("lu_x0", V_RUN);
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_write_addr = 5'd7; id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1;
        id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1;
        #1 chk("lu_rs2", V_LU);
        @(negedge clk); id_uses_rs2 = 1'b0; #1 chk("lu_rs2_unused", V_RUN);

        // Branch overrides load-use
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_write_addr = 5'd9; id_rs1_addr = 5'd9; id_uses_rs1 = 1'b1;
        ex_branch_taken = 1'b1;
        #1 chk("br_over_lu", V_BR);
        @(negedge clk); idle(); #1 chk("br_after", V_RUN);

        // imem wait for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); imem_busywait = 1'b1; #1 chk("imem_busy", V_IM);
        end
        @(negedge clk); idle(); #1 chk("imem_after", V_RUN);
        @(negedge clk); imem_busywait = 1'b1; ex_mem_read = 1'b1; ex_write_addr = 5'd4;
        id_rs1_addr = 5'd4; id_uses_rs1 = 1'b1;
        #1 chk("imem_vs_lu", V_LU);
        @(negedge clk); idle(); dmem_busywait = 1'b1; ex_branch_taken = 1'b1; #1 chk("dmem_run", V_ZERO);

        // DIV: 32 cycles of EX stall, 31 busy, one done, no restart
        idex_low = 0;
        @(negedge clk); idle(); ex_muldiv_start = 1'b1; ex_is_div = 1'b1; ex_branch_taken = 1'b1;
        #1 chk("div_start", V_START);
        if (!id_ex_en) idex_low++;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk); #1 chk("div_busy", V_MD);
            if (!id_ex_en) idex_low++;
        end
        @(negedge clk); ex_branch_taken = 1'b0; #1 chk("div_done", V_DONE);
        if (!id_ex_en) idex_low++;
        chk_int("div_stall_cycles", idex_low, 32);
        @(negedge clk); idle(); #1 chk("div_after", V_RUN);

        // MUL with dmem wait in MULDIV cycles 1-4
        @(negedge clk); idle(); ex_muldiv_start = 1'b1; ex_is_div = 1'b0; #1 chk("mul_start", V_START);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); dmem_busywait = 1'b1; #1 chk("mul_freeze", V_FRZMD);
        end
        @(negedge clk); dmem_busywait = 1'b0; #1 chk("mul_exit", V_MD);
        @(negedge clk); #1 chk("mul_done", V_DONE);
        @(negedge clk); idle(); #1 chk("mul_after", V_RUN);

        // Reset while a DIV is in flight with 10 cycles left
        @(negedge clk); idle(); ex_muldiv_start = 1'b1; ex_is_div = 1'b1; #1 chk("rdiv_start", V_START);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk); #1 chk("rdiv_busy", V_MD);
        end
        @(negedge clk); reset = 1'b1; #1 chk("rdiv_in_reset", V_ZERO);
        @(negedge clk); reset = 1'b0; idle(); #1 chk("rdiv_release", V_RUN);
        @(negedge clk); #1 chk("rdiv_no_done", V_RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
